// File: rtl/cpu8bit_pkg.sv
// rtl/cpu8bit_pkg.sv - shared types and UART frame constants for the CPU output port
package cpu8bit_pkg;

  localparam int DATA_W     = 8;
  localparam int START_BITS = 1;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/out_fifo.sv
// rtl/out_fifo.sv - synchronous FIFO with registered full/empty flags
module out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count_n;
  logic             do_push;
  logic             do_pop;

  // Flags are the registered view, so a pop cannot rescue a write made while full.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_comb begin
    count_n = count;
    case ({do_push, do_pop})
      2'b10:   count_n = count + (AW+1)'(1);
      2'b01:   count_n = count - (AW+1)'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count_n;
      full  <= (count_n == (AW+1)'(DEPTH));
      empty <= (count_n == '0);
    end
  end

endmodule

// File: rtl/cpu8bit_out_port.sv
// rtl/cpu8bit_out_port.sv - CPU write capture into a FIFO, drained as 8N1 UART frames
module cpu8bit_out_port
  import cpu8bit_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              wr_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              busy_o,
  output logic              drop_o,
  output logic              tx_o
);

  localparam int               BW        = $clog2(CLK_DIV);
  localparam logic [BW-1:0]    BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_t         state;
  logic [BW-1:0]     baud;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] fifo_rdata;
  logic              push;
  logic              pop;
  logic              baud_last;

  assign baud_last = (baud == BAUD_LAST);
  assign push      = wr_i & ~full_o & ~rst_i;
  // Popping on the last stop cycle lets the next start bit follow with no idle gap.
  assign pop       = ~empty_o & ((state == IDLE) | ((state == STOP) & baud_last));

  out_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (data_i),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full_o),
    .empty (empty_o),
    .count ()
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_o    <= 1'b1;
      busy_o  <= 1'b0;
      drop_o  <= 1'b0;
    end else begin
      drop_o <= wr_i & full_o;
      // tx_o and busy_o are loaded with the value belonging to the next state.
      case (state)
        IDLE: begin
          if (!empty_o) begin
            shreg   <= fifo_rdata;
            bit_idx <= '0;
            baud    <= '0;
            state   <= START;
            tx_o    <= 1'b0;
            busy_o  <= 1'b1;
          end
        end
        START: begin
          if (baud_last) begin
            baud  <= '0;
            state <= DATA;
            tx_o  <= shreg[0];
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud <= '0;
            if (bit_idx == BIT_LAST) begin
              state <= STOP;
              tx_o  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx_o    <= shreg[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud <= '0;
            if (!empty_o) begin
              shreg   <= fifo_rdata;
              bit_idx <= '0;
              state   <= START;
              tx_o    <= 1'b0;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu8bit_out_port.sv
// tb/tb_cpu8bit_out_port.sv - directed self-checking bench for cpu8bit_out_port
module tb_cpu8bit_out_port;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       wr;
  logic       full, empty, busy, drop, tx;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] rx_byte;
  int         rx_cnt;
  bit         rx_active = 0;
  int         frame_err = 0;
  int         drop_cnt  = 0;

  cpu8bit_out_port #(
    .CLK_DIV    (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .data_i  (data),
    .wr_i    (wr),
    .full_o  (full),
    .empty_o (empty),
    .busy_o  (busy),
    .drop_o  (drop),
    .tx_o    (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Line receiver: start cycle is count 0, data bit k centred at 6+4k, stop at 38.
  initial begin
    forever begin
      @(negedge clk);
      if (drop === 1'b1) drop_cnt++;
      if (rst === 1'b1) begin
        rx_active = 0;
      end else if (!rx_active) begin
        if (tx === 1'b0) begin
          rx_active = 1;
          rx_cnt    = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 6) % 4) == 0)
          rx_byte[(rx_cnt - 6) / 4] = tx;
        if (rx_cnt == 38) begin
          if (tx !== 1'b1) frame_err++;
          rx_q.push_back(rx_byte);
          rx_active = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic [7:0] b);
    logic exp_tx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 4)       exp_tx = 1'b0;
      else if (i < 36) exp_tx = b[(i - 4) / 4];
      else             exp_tx = 1'b1;
      chk("frame_tx", tx, exp_tx);
      chk("frame_busy", busy, 1'b1);
      tick();
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("rx_count", rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(busy === 1'b0 && empty === 1'b1) && k < budget) begin
      tick();
      k++;
    end
    chk("idle_reached", (k < budget), 1'b1);
  endtask

  initial begin
    rst  = 1'b1;
    wr   = 1'b0;
    data = 8'h00;

    // Reset values held throughout a 3-cycle reset and after release.
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_drop", drop, 1'b0);
    end
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("post_rst_tx", tx, 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_empty", empty, 1'b1);
    tick();

    // Single byte 0xA5, cycle-exact.
    rx_q.delete();
    wr = 1'b1; data = 8'hA5;
    tick();
    wr = 1'b0;
    @(negedge clk);
    chk("single_c1_tx", tx, 1'b1);
    chk("single_c1_busy", busy, 1'b0);
    chk("single_c1_empty", empty, 1'b0);
    tick();
    expect_frame(8'hA5);
    @(negedge clk);
    chk("single_c42_busy", busy, 1'b0);
    chk("single_c42_tx", tx, 1'b1);
    chk("single_c42_empty", empty, 1'b1);
    chk("single_rx_n", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("single_rx", rx_q[0], 8'hA5);
    tick();
    tick();

    // Back-to-back frames with no gap.
    rx_q.delete();
    wr = 1'b1; data = 8'h01;
    tick();
    data = 8'h02;
    tick();
    wr = 1'b0;
    expect_frame(8'h01);
    expect_frame(8'h02);
    @(negedge clk);
    chk("b2b_busy_end", busy, 1'b0);
    chk("b2b_rx_n", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("b2b_rx0", rx_q[0], 8'h01);
      chk("b2b_rx1", rx_q[1], 8'h02);
    end
    tick();
    tick();

    // Overflow: 0x10..0x15 in consecutive cycles, 0x15 dropped.
    rx_q.delete();
    drop_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      wr = 1'b1; data = 8'h10 + 8'(c);
      @(negedge clk);
      chk("ovf_full", full, (c >= 5));
      chk("ovf_drop_pre", drop, 1'b0);
      tick();
    end
    wr = 1'b0;
    @(negedge clk);
    chk("ovf_drop_c6", drop, 1'b1);
    tick();
    @(negedge clk);
    chk("ovf_drop_c7", drop, 1'b0);
    wait_rx(5, 400);
    wait_idle(200);
    chk("ovf_rx_total", rx_q.size(), 5);
    chk("ovf_drop_count", drop_cnt, 1);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      chk("ovf_rx", rx_q[i], 8'h10 + 8'(i));
    tick();

    // Reset mid-frame at cycle 20, with a write in the reset cycle ignored.
    wr = 1'b1; data = 8'h55;
    tick();
    wr = 1'b0;
    repeat (19) tick();
    rst = 1'b1; wr = 1'b1; data = 8'h77;
    tick();
    rst = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_full", full, 1'b0);
    tick();
    @(negedge clk);
    chk("mid_rst_still_empty", empty, 1'b1);
    chk("mid_rst_still_idle", busy, 1'b0);
    tick();
    rx_q.delete();
    wr = 1'b1; data = 8'h3C;
    tick();
    wr = 1'b0;
    @(negedge clk);
    chk("rearm_c1_tx", tx, 1'b1);
    tick();
    expect_frame(8'h3C);
    chk("rearm_rx_n", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("rearm_rx", rx_q[0], 8'h3C);
    wait_idle(50);

    // Pointer wrap: 10 bytes, one every 40 cycles.
    rx_q.delete();
    drop_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      wr = 1'b1; data = 8'(k);
      tick();
      wr = 1'b0;
      repeat (39) tick();
    end
    wait_rx(10, 200);
    for (int i = 0; i < 10 && i < rx_q.size(); i++)
      chk("wrap_rx", rx_q[i], 8'(i));
    chk("wrap_drop_count", drop_cnt, 0);
    wait_idle(100);
    chk("frame_err", frame_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu8bit_out_port.md
# cpu8bit_out_port

Output port for the 8-bit CPU. It captures bytes the CPU places on its 8-bit data bus when the operation unit's write strobe is active, and buffers them in a small synchronous FIFO. It then serialises them as 8N1 UART frames on a single output pin. It sits directly downstream of the CPU top-level data bus and is its only path off-chip.

## Interface
Parameters:
- CLK_DIV, default 16: clock cycles per UART bit; legal range ≥ 2.
- FIFO_DEPTH, default 4: FIFO entries; must be a power of 2, ≥ 2.

Ports:
- clk_i, in, 1: single clock; all state updates on its rising edge.
- rst_i, in, 1: reset, synchronous, active-high.
- data_i, in, 8: byte from the CPU data bus.
- wr_i, in, 1: write strobe, sampled every cycle; one byte per cycle it is high.
- full_o, out, 1: FIFO holds FIFO_DEPTH entries (registered).
- empty_o, out, 1: FIFO holds 0 entries (registered).
- busy_o, out, 1: transmitter is not in IDLE.
- drop_o, out, 1: one-cycle pulse, in the cycle after a write was rejected.
- tx_o, out, 1: serial line, registered, idles high.

## Operation
- **Write:**
  - A cycle with wr_i=1 and full_o=0 stores data_i at the write pointer.
  - A cycle with wr_i=1 and full_o=1 discards the byte and sets drop_o for the next cycle only.
  - full_o is evaluated on the registered count. A pop in the same cycle does not rescue a write made while full.
- **Simultaneous push and pop:** the count is unchanged and both pointers advance. With count 0 there is no pop, because the pop needs the entry to be already registered.
- **Pointers and count:**
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
  - The count is log2(FIFO_DEPTH)+1 bits wide.
- **Transmit FSM states:** IDLE, START, DATA, STOP.
- **IDLE:**
  - tx_o=1.
  - If empty_o=0: pop the head entry into the shift register, clear the bit counter, and go to START.
- **START:** tx_o=0 for CLK_DIV cycles, then go to DATA.
- **DATA:**
  - Shifts out 8 bits LSB first, each held CLK_DIV cycles.
  - A 3-bit bit index counts up to 7, then the FSM goes to STOP.
- **STOP:**
  - tx_o=1 for CLK_DIV cycles.
  - On the last STOP cycle, if empty_o=0, pop and go directly to START, so frames are back-to-back with no gap. Otherwise go to IDLE.
- **Baud counter:** $clog2(CLK_DIV) bits. It reloads to 0 on every state or bit change and counts to CLK_DIV-1.
- **Reset:**
  - Clears pointers and count, forces state IDLE, and zeroes the counters and shift register.
  - Reset values: tx_o=1, busy_o=0, empty_o=1, full_o=0, drop_o=0.
  - A reset mid-frame aborts the frame. tx_o is high in the cycle after rst_i is sampled, and buffered bytes are lost.
  - wr_i is ignored in a reset cycle.

## Timing
- **Write to line:** wr_i in cycle 0 with the FIFO empty and the FSM in IDLE:
  - the entry is visible in cycle 1 and is popped in cycle 1;
  - tx_o falls in cycle 2.
- **Frame length:** exactly 10·CLK_DIV cycles. busy_o is high for exactly those cycles.
- **Per-byte throughput:** one byte per 10·CLK_DIV cycles in steady state.
- **Output timing:** all outputs come directly from flops. There are no combinational paths from input to output.

## Structure
- **Package cpu8bit_pkg:**
  - DATA_W = 8;
  - enum tx_state_t {IDLE, START, DATA, STOP};
  - UART frame constants: 1 start bit, 8 data bits, 1 stop bit.
- **Sub-module out_fifo:** synchronous FIFO, parameterised by width and depth. It provides push, pop, rdata, full, empty and count.
- **Top:** cpu8bit_out_port instantiates out_fifo and contains the transmit FSM, baud counter and shift register.

## Test plan
All scenarios use CLK_DIV=4 and FIFO_DEPTH=4.
- **Reset values:** hold rst_i for 3 cycles → tx_o=1, empty_o=1, full_o=0, busy_o=0, drop_o=0 throughout and after.
- **Single byte:** write 0xA5 in cycle 0 → tx_o=0 in cycles 2–5. Data bits 1,0,1,0,0,1,0,1 (LSB first) follow, 4 cycles each, in cycles 6–37. Stop bit is high in cycles 38–41. busy_o is high in cycles 2–41 and low from cycle 42.
- **Back-to-back:** write 0x01 in cycle 0 and 0x02 in cycle 1 → the second start bit begins at cycle 42. tx_o has no high gap between the stop bit at cycles 38–41 and that start bit.
- **Overflow:** write 0x10..0x15 in cycles 0–5 → full_o high from cycle 5. 0x15 is dropped, and drop_o is high in cycle 6 only. The line carries 0x10..0x14 in order.
- **Reset mid-frame:** with a frame in progress, assert rst_i in cycle 20 → from cycle 21, tx_o=1, busy_o=0, empty_o=1. A fresh write of 0x3C then transmits correctly with standard latency.
- **Pointer wrap:** stream 10 bytes 0x00..0x09 with one write every 40 cycles → all are received intact and in order as the pointers wrap twice. drop_o is never asserted.
